// File: rtl/i2c_master_reader_if.sv
// i2c_master_reader_if: host request/response and SCL/SDA-drive signals of the I2C read master
interface i2c_master_reader_if #(
    parameter int MEM_ADDR_WIDTH = 16,
    parameter int LEN_WIDTH      = 8
);
    logic                      in_start;
    logic [MEM_ADDR_WIDTH-1:0] in_addr;
    logic [LEN_WIDTH-1:0]      in_len;
    logic                      out_busy;
    logic [7:0]                out_data;
    logic                      out_data_valid;
    logic                      out_done;
    logic                      out_nack;
    logic                      out_scl;
    logic                      out_sda_dir;

    modport master (
        input  in_start, in_addr, in_len,
        output out_busy, out_data, out_data_valid, out_done, out_nack, out_scl, out_sda_dir
    );

    modport slave (
        output in_start, in_addr, in_len,
        input  out_busy, out_data, out_data_valid, out_done, out_nack, out_scl, out_sda_dir
    );
endinterface

// File: rtl/i2c_master_reader.sv
// i2c_master_reader: I2C master doing random-address sequential reads from a 16-bit-addressed slave
module i2c_master_reader #(
    parameter int         CLK_DIV        = 16,
    parameter logic [6:0] DEV_ADDR       = 7'h50,
    parameter int         MEM_ADDR_WIDTH = 16,
    parameter int         LEN_WIDTH      = 8
) (
    input  logic                in_clk,
    input  logic                in_rst_n,
    i2c_master_reader_if.master bus,
    inout  wire                 io_sda
);
    typedef enum logic [2:0] {IDLE, START, TX_BYTE, RX_ACK, RESTART, RX_BYTE, TX_ACK, STOP} state_t;

    localparam int DW = $clog2(CLK_DIV);

    state_t                    r_state, w_state_nxt;
    logic [DW-1:0]             r_div;
    logic [1:0]                r_q;
    logic [2:0]                r_bit;
    logic [1:0]                r_byte;
    logic [7:0]                r_shift;
    logic [MEM_ADDR_WIDTH-1:0] r_addr;
    logic [LEN_WIDTH-1:0]      r_len;
    logic                      r_ack;
    logic [7:0]                r_data;
    logic                      r_valid;
    logic                      r_done;
    logic                      r_nack;
    logic                      r_scl;
    logic                      r_sda_pre;
    logic                      r_sda_dir;
    logic                      w_tick;
    logic                      w_sample;
    logic                      w_slot_end;
    logic                      w_accept;
    logic                      w_scl;
    logic                      w_sda_dir;
    logic [15:0]               w_addr16;

    assign w_tick     = (r_state != IDLE) && (r_div == DW'(CLK_DIV - 1));
    assign w_sample   = w_tick && (r_q == 2'd2);
    assign w_slot_end = w_tick && (r_q == 2'd3);
    assign w_accept   = (r_state == IDLE) && bus.in_start;
    assign w_addr16   = 16'(r_addr);

    // Quarter-period prescaler; parked at zero while idle so every transaction starts on a clean slot
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            r_div <= '0;
            r_q   <= '0;
        end else if (r_state == IDLE) begin
            r_div <= '0;
            r_q   <= '0;
        end else begin
            r_div <= w_tick ? '0 : r_div + 1'b1;
            if (w_tick) r_q <= r_q + 2'd1;
        end
    end

    // State register
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) r_state <= IDLE;
        else           r_state <= w_state_nxt;
    end

    // Next state and per-quarter SCL/SDA waveform of the current slot
    always_comb begin
        w_state_nxt = r_state;
        w_scl       = 1'b1;
        w_sda_dir   = 1'b0;
        case (r_state)
            IDLE: if (w_accept && bus.in_len != '0) w_state_nxt = START;
            START: begin
                w_scl     = (r_q != 2'd3);
                w_sda_dir = r_q[1];
                if (w_slot_end) w_state_nxt = TX_BYTE;
            end
            RESTART: begin
                w_scl     = (r_q == 2'd1) || (r_q == 2'd2);
                w_sda_dir = r_q[1];
                if (w_slot_end) w_state_nxt = TX_BYTE;
            end
            TX_BYTE: begin
                w_scl     = r_q[1];
                w_sda_dir = ~r_shift[7];
                if (w_slot_end && r_bit == 3'd7) w_state_nxt = RX_ACK;
            end
            RX_ACK: begin
                w_scl = r_q[1];
                if (w_slot_end)
                    w_state_nxt = r_ack ? STOP : (r_byte == 2'd2) ? RESTART : (r_byte == 2'd3) ? RX_BYTE : TX_BYTE;
            end
            RX_BYTE: begin
                w_scl = r_q[1];
                if (w_slot_end && r_bit == 3'd7) w_state_nxt = TX_ACK;
            end
            TX_ACK: begin
                w_scl     = r_q[1];
                w_sda_dir = (r_len != '0);
                if (w_slot_end) w_state_nxt = (r_len != '0) ? RX_BYTE : STOP;
            end
            STOP: begin
                w_scl     = (r_q != 2'd0);
                w_sda_dir = ~r_q[1];
                if (w_slot_end) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Request latch, shift register, bit/byte counters and host-side status pulses
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            r_bit   <= '0;
            r_byte  <= '0;
            r_shift <= '0;
            r_addr  <= '0;
            r_len   <= '0;
            r_ack   <= 1'b0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            r_nack  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            if (w_accept) begin
                r_nack <= 1'b0;
                r_addr <= bus.in_addr;
                r_len  <= bus.in_len;
                r_done <= (bus.in_len == '0);
            end
            if (w_sample) begin
                r_ack <= io_sda;
                if (r_state == RX_BYTE) r_shift <= {r_shift[6:0], io_sda};
                if (r_state == RX_BYTE && r_bit == 3'd7) begin
                    r_data  <= {r_shift[6:0], io_sda};
                    r_valid <= 1'b1;
                    r_len   <= (r_len != '0) ? r_len - 1'b1 : '0;
                end
            end
            if (w_slot_end) begin
                case (r_state)
                    START: begin
                        r_shift <= {DEV_ADDR, 1'b0};
                        r_byte  <= 2'd0;
                        r_bit   <= 3'd0;
                    end
                    RESTART: r_shift <= {DEV_ADDR, 1'b1};
                    TX_BYTE: begin
                        r_bit   <= r_bit + 3'd1;
                        r_shift <= {r_shift[6:0], 1'b0};
                    end
                    RX_BYTE: r_bit <= r_bit + 3'd1;
                    RX_ACK: begin
                        if (r_ack) begin
                            r_nack <= 1'b1;
                        end else begin
                            r_shift <= (r_byte == 2'd0) ? w_addr16[15:8] : w_addr16[7:0];
                            r_byte  <= r_byte + 2'd1;
                        end
                    end
                    STOP: r_done <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

    // Registered bus drive; SDA trails SCL by one cycle so data never moves on an SCL edge
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            r_scl     <= 1'b1;
            r_sda_pre <= 1'b0;
            r_sda_dir <= 1'b0;
        end else begin
            r_scl     <= w_scl;
            r_sda_pre <= w_sda_dir;
            r_sda_dir <= r_sda_pre;
        end
    end

    assign io_sda             = r_sda_dir ? 1'b0 : 1'bz;
    assign bus.out_scl        = r_scl;
    assign bus.out_sda_dir    = r_sda_dir;
    assign bus.out_busy       = (r_state != IDLE);
    assign bus.out_data       = r_data;
    assign bus.out_data_valid = r_valid;
    assign bus.out_done       = r_done;
    assign bus.out_nack       = r_nack;
endmodule

// File: tb/tb_i2c_master_reader.sv
// tb_i2c_master_reader: random and directed reads against a behavioural I2C memory slave
module tb_i2c_master_reader;
    localparam int CLK_DIV = 4;
    localparam int TMO     = 5000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    i2c_master_reader_if #(16, 8) bus_a ();
    i2c_master_reader_if #(16, 8) bus_b ();

    wire sda_a;
    wire sda_b;
    pullup (sda_a);
    pullup (sda_b);

    // The slave model serves DUT A (sel=0) or the mis-addressed DUT B (sel=1)
    logic sel    = 1'b0;
    logic s_pull = 1'b0;
    assign sda_a = (!sel && s_pull) ? 1'b0 : 1'bz;
    assign sda_b = (sel && s_pull) ? 1'b0 : 1'bz;

    logic bus_scl;
    logic bus_sda;
    assign bus_scl = sel ? bus_b.out_scl : bus_a.out_scl;
    assign bus_sda = sel ? sda_b : sda_a;

    i2c_master_reader #(.CLK_DIV(CLK_DIV)) dut_a (
        .in_clk(clk), .in_rst_n(rst_n), .bus(bus_a), .io_sda(sda_a)
    );
    i2c_master_reader #(.CLK_DIV(CLK_DIV), .DEV_ADDR(7'h51)) dut_b (
        .in_clk(clk), .in_rst_n(rst_n), .bus(bus_b), .io_sda(sda_b)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] mem(input logic [15:0] a);
        return a[7:0] ^ 8'hA5;
    endfunction

    logic [7:0] bus_q[$];
    int         mack_q[$];
    logic [7:0] vq[$];
    int         n_start, n_stop, n_pulse, n_done, hi_chg, hi_len, hi_min, hi_max;
    logic       rise_seen;

    task automatic clear_logs();
        bus_q.delete();
        mack_q.delete();
        vq.delete();
        n_start = 0; n_stop = 0; n_pulse = 0; n_done = 0; hi_chg = 0;
        hi_len = 0; hi_min = 1000; hi_max = 0; rise_seen = 1'b0;
    endtask

    // Bus monitor and memory slave, sampled mid-cycle
    initial begin
        logic       pscl, psda, scl, sda, active, tx, addressed, rw;
        logic [7:0] sh, txd;
        logic [15:0] ptr;
        int         cnt, byte_no;
        pscl = 1; psda = 1; active = 0; tx = 0; addressed = 0; rw = 0;
        sh = 0; txd = 0; ptr = 0; cnt = 0; byte_no = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                s_pull = 0; active = 0; tx = 0; pscl = 1; psda = 1;
            end else begin
                scl = bus_scl;
                sda = bus_sda;
                if (sel ? bus_b.out_data_valid : bus_a.out_data_valid)
                    vq.push_back(sel ? bus_b.out_data : bus_a.out_data);
                if (sel ? bus_b.out_done : bus_a.out_done) n_done++;
                if (!pscl && scl) hi_len = 0;
                if (scl) hi_len++;
                if (pscl && scl && psda != sda) hi_chg++;
                if (pscl && scl && psda && !sda) begin
                    n_start++; active = 1; cnt = 0; byte_no = 0; tx = 0; s_pull = 0;
                end else if (pscl && scl && !psda && sda) begin
                    n_stop++; active = 0; s_pull = 0;
                end else if (!pscl && scl) begin
                    rise_seen = 1;
                    if (active) begin
                        if (!tx && cnt < 8) sh = {sh[6:0], sda};
                        if (tx && cnt == 8) mack_q.push_back(int'(sda));
                        cnt++;
                    end
                end else if (pscl && !scl) begin
                    if (rise_seen) begin
                        n_pulse++;
                        if (hi_len < hi_min) hi_min = hi_len;
                        if (hi_len > hi_max) hi_max = hi_len;
                    end
                    if (active && !tx) begin
                        if (cnt == 8) begin
                            bus_q.push_back(sh);
                            if (byte_no == 0) begin
                                addressed = (sh[7:1] == 7'h50);
                                rw = sh[0];
                            end else if (addressed && !rw && byte_no == 1) ptr[15:8] = sh;
                            else if (addressed && !rw && byte_no == 2) ptr[7:0] = sh;
                            s_pull = addressed;
                            byte_no++;
                        end else if (cnt == 9) begin
                            s_pull = 0; cnt = 0;
                            if (addressed && rw) begin
                                tx = 1; txd = mem(ptr); s_pull = !txd[7];
                            end
                        end
                    end else if (active && tx) begin
                        if (cnt < 8) s_pull = !txd[7-cnt];
                        else if (cnt == 8) s_pull = 0;
                        else begin
                            cnt = 0;
                            if (mack_q[$] == 0) begin
                                ptr++; txd = mem(ptr); s_pull = !txd[7];
                            end else begin
                                s_pull = 0; active = 0;
                            end
                        end
                    end
                end
                pscl = scl;
                psda = sda;
            end
        end
    end

    task automatic run_read(input logic [15:0] addr, input logic [7:0] len, input bit poke);
        logic [7:0] exp_q[$];
        logic [7:0] exp_bus[4];
        int t;
        exp_bus = '{8'hA0, addr[15:8], addr[7:0], 8'hA1};
        for (int i = 0; i < int'(len); i++) exp_q.push_back(mem(addr + 16'(i)));
        clear_logs();
        @(posedge clk); #1;
        bus_a.in_start = 1; bus_a.in_addr = addr; bus_a.in_len = len;
        @(posedge clk); #1;
        bus_a.in_start = 0; bus_a.in_addr = 16'($urandom); bus_a.in_len = 8'($urandom_range(1, 9));
        check("busy_after_start", bus_a.out_busy, 1);
        t = 0;
        while (bus_a.out_done !== 1'b1 && t < TMO) begin
            @(posedge clk); #1;
            t++;
            bus_a.in_start = poke && (t == 300);
        end
        bus_a.in_start = 0;
        check("done_in_time", t < TMO, 1);
        check("busy_at_done", bus_a.out_busy, 0);
        repeat (4) @(posedge clk);
        #1;
        check("done_pulses", n_done, 1);
        check("nack_clear", bus_a.out_nack, 0);
        check("valid_count", vq.size(), len);
        for (int i = 0; i < int'(len); i++)
            if (i < vq.size()) check($sformatf("data[%0d]", i), vq[i], exp_q[i]);
        check("last_data", bus_a.out_data, exp_q[$]);
        check("bus_bytes", bus_q.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < bus_q.size()) check($sformatf("bus_byte[%0d]", i), bus_q[i], exp_bus[i]);
        check("master_acks", mack_q.size(), len);
        for (int i = 0; i < mack_q.size(); i++)
            check($sformatf("mack[%0d]", i), mack_q[i], (i == int'(len) - 1) ? 1 : 0);
        check("starts", n_start, 2);
        check("stops", n_stop, 1);
        check("scl_pulses", n_pulse, 37 + 9 * int'(len));
        check("sda_moves_scl_high", hi_chg, 3);
        check("scl_high_min", hi_min, 2 * CLK_DIV);
        check("scl_high_max", hi_max, 2 * CLK_DIV);
    endtask

    initial begin
        int t;
        logic stayed;
        bus_a.in_start = 0; bus_a.in_addr = 0; bus_a.in_len = 0;
        bus_b.in_start = 0; bus_b.in_addr = 0; bus_b.in_len = 0;
        clear_logs();
        repeat (3) @(posedge clk);
        #1;
        check("rst_scl", bus_a.out_scl, 1);
        check("rst_sda_dir", bus_a.out_sda_dir, 0);
        rst_n = 1;
        @(posedge clk); #1;
        check("rst_busy", bus_a.out_busy, 0);
        check("rst_data", bus_a.out_data, 0);
        check("rst_valid", bus_a.out_data_valid, 0);
        check("rst_done", bus_a.out_done, 0);
        check("rst_nack", bus_a.out_nack, 0);

        run_read(16'h0000, 8'd1, 0);
        run_read(16'h01FE, 8'd4, 0);
        for (int k = 0; k < 6; k++)
            run_read(16'($urandom), 8'($urandom_range(1, 5)), k == 2);

        // zero-length request: immediate done, bus untouched
        clear_logs();
        @(posedge clk); #1;
        bus_a.in_start = 1; bus_a.in_len = 0;
        @(posedge clk); #1;
        bus_a.in_start = 0;
        check("len0_done", bus_a.out_done, 1);
        check("len0_busy", bus_a.out_busy, 0);
        stayed = 1;
        repeat (40) begin
            @(posedge clk); #1;
            stayed &= bus_a.out_scl & !bus_a.out_busy;
        end
        check("len0_scl_idle", stayed, 1);
        check("len0_no_start", n_start, 0);

        // DUT B addresses 0x51: no slave answers
        sel = 1;
        clear_logs();
        @(posedge clk); #1;
        bus_b.in_start = 1; bus_b.in_addr = 16'($urandom); bus_b.in_len = 8'd3;
        @(posedge clk); #1;
        bus_b.in_start = 0;
        t = 0;
        while (bus_b.out_done !== 1'b1 && t < TMO) begin
            @(posedge clk); #1;
            t++;
        end
        check("nack_done_in_time", t < TMO, 1);
        check("nack_flag", bus_b.out_nack, 1);
        repeat (20) @(posedge clk);
        #1;
        check("nack_held", bus_b.out_nack, 1);
        check("nack_pulses", n_pulse, 9);
        check("nack_stops", n_stop, 1);
        check("nack_done_pulses", n_done, 1);
        check("nack_no_valid", vq.size(), 0);
        check("nack_dev_byte", bus_q.size() > 0 ? bus_q[0] : 8'h00, 8'hA2);
        bus_b.in_start = 1; bus_b.in_len = 0;
        @(posedge clk); #1;
        bus_b.in_start = 0;
        check("nack_cleared", bus_b.out_nack, 0);
        sel = 0;

        // asynchronous reset in the middle of byte 2 of a 4-byte read
        clear_logs();
        @(posedge clk); #1;
        bus_a.in_start = 1; bus_a.in_addr = 16'($urandom); bus_a.in_len = 8'd4;
        @(posedge clk); #1;
        bus_a.in_start = 0;
        t = 0;
        while (vq.size() == 0 && t < TMO) begin
            @(posedge clk); #1;
            t++;
        end
        check("rst_test_byte1", t < TMO, 1);
        repeat (5 * 4 * CLK_DIV) @(posedge clk);
        #3;
        rst_n = 0;
        #1;
        check("midrst_scl", bus_a.out_scl, 1);
        check("midrst_sda_dir", bus_a.out_sda_dir, 0);
        check("midrst_busy", bus_a.out_busy, 0);
        check("midrst_data", bus_a.out_data, 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1;
        repeat (3) @(posedge clk);
        run_read(16'h0010, 8'd1, 0);
        check("after_rst_data", bus_a.out_data, 8'hB5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
